// File: rtl/md5_crack_ctrl_if.sv
// md5_crack_ctrl_if: request/response bundle between the cracking
// controller (master) and the single-block MD5 core (slave).
interface md5_crack_ctrl_if;
  logic [63:0]  md5_msg;
  logic         md5_start;
  logic         md5_done;
  logic [127:0] md5_hash;

  modport master (
    output md5_msg, md5_start,
    input  md5_done, md5_hash
  );

  modport slave (
    input  md5_msg, md5_start,
    output md5_done, md5_hash
  );
endinterface

// File: rtl/md5_crack_ctrl.sv
// md5_crack_ctrl: walks a BCD password range, feeds the MD5 core, checks
// digests. Optional watchdog: define MD5_CRACK_TIMEOUT_EN.
module md5_crack_ctrl #(
  parameter int STEP  = 1,
  parameter int CNT_W = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  input  logic [31:0]       range_lo,
  input  logic [31:0]       range_hi,
  input  logic [127:0]      target_hash,
  md5_crack_ctrl_if.master  md5,
  output logic              busy,
  output logic              found,
  output logic [63:0]       found_msg,
  output logic              exhausted,
  output logic [CNT_W-1:0]  tried_count
`ifdef MD5_CRACK_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CHECK, NEXT, DRAIN
  } state_t;

  state_t state, state_n;

  logic [31:0]  cand;
  logic [31:0]  hi_q;
  logic [127:0] tgt_q;
  logic [127:0] hash_q;
  logic [63:0]  msg;
  logic [31:0]  nxt;
  logic         carry;
  logic [4:0]   dsum;
  logic         hit;
  logic         load;
  logic         empty;
  logic         take;
  logic         check;
  logic         adv;
  logic         done_exh;

`ifdef MD5_CRACK_TIMEOUT_EN
  logic [7:0] wdog;
  logic       wd_exp;
  logic       tmo;
  assign wd_exp = (wdog == 8'hff);
`endif

  function automatic logic [63:0] to_ascii(input logic [31:0] b);
    logic [63:0] a;
    for (int i = 0; i < 8; i++) a[8*i +: 8] = {4'h3, b[4*i +: 4]};
    return a;
  endfunction

  assign md5.md5_msg   = msg;
  assign md5.md5_start = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign hit           = (hash_q == tgt_q);

  // Ripple BCD add of STEP to the current candidate
  always_comb begin
    nxt   = '0;
    carry = 1'b0;
    dsum  = '0;
    for (int i = 0; i < 8; i++) begin
      dsum = {1'b0, cand[4*i +: 4]} + {4'd0, carry}
           + ((i == 0) ? 5'(STEP) : 5'd0);
      if (dsum > 5'd9) begin
        nxt[4*i +: 4] = 4'(dsum - 5'd10);
        carry = 1'b1;
      end else begin
        nxt[4*i +: 4] = dsum[3:0];
        carry = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    empty    = 1'b0;
    take     = 1'b0;
    check    = 1'b0;
    adv      = 1'b0;
    done_exh = 1'b0;
`ifdef MD5_CRACK_TIMEOUT_EN
    tmo      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (go) begin
          if (range_lo > range_hi) begin
            empty = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: state_n = abort ? DRAIN : WAIT;
      WAIT: begin
        if (abort) begin
          state_n = md5.md5_done ? IDLE : DRAIN;
        end else if (md5.md5_done) begin
          take    = 1'b1;
          state_n = CHECK;
`ifdef MD5_CRACK_TIMEOUT_EN
        end else if (wd_exp) begin
          tmo     = 1'b1;
          state_n = IDLE;
`endif
        end
      end
      CHECK: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          check   = 1'b1;
          state_n = hit ? IDLE : NEXT;
        end
      end
      NEXT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (carry || nxt > hi_q) begin
          done_exh = 1'b1;
          state_n  = IDLE;
        end else begin
          adv     = 1'b1;
          state_n = ISSUE;
        end
      end
      DRAIN: begin
        if (md5.md5_done) begin
          state_n = IDLE;
`ifdef MD5_CRACK_TIMEOUT_EN
        end else if (wd_exp) begin
          tmo     = 1'b1;
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Job registers, candidate, digest capture and sticky results
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand        <= '0;
      hi_q        <= '0;
      tgt_q       <= '0;
      hash_q      <= '0;
      msg         <= '0;
      found       <= 1'b0;
      found_msg   <= '0;
      exhausted   <= 1'b0;
      tried_count <= '0;
    end else begin
      if (load || empty) begin
        cand        <= range_lo;
        hi_q        <= range_hi;
        tgt_q       <= target_hash;
        found       <= 1'b0;
        found_msg   <= '0;
        exhausted   <= 1'b0;
        tried_count <= '0;
      end
      if (empty)    exhausted <= 1'b1;
      if (load)     msg <= to_ascii(range_lo);
      if (take)     hash_q <= md5.md5_hash;
      if (check) begin
        tried_count <= tried_count + CNT_W'(1);
        if (hit) begin
          found     <= 1'b1;
          found_msg <= msg;
        end
      end
      if (done_exh) exhausted <= 1'b1;
      if (adv) begin
        cand <= nxt;
        msg  <= to_ascii(nxt);
      end
    end
  end

`ifdef MD5_CRACK_TIMEOUT_EN
  // Watchdog on the core response, restarted at every issue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == ISSUE) wdog <= '0;
      else if (state == WAIT || state == DRAIN) wdog <= wdog + 8'd1;
      if (load || empty) timeout <= 1'b0;
      if (tmo)           timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/md5_crack_ctrl.md
Name: md5_crack_ctrl

Overview:
Candidate-generation and result-check controller that sits directly upstream of the single-block MD5 core in the password-cracking datapath. It walks a BCD range of 8-digit decimal passwords and presents each one to the core as 8 ASCII bytes. For each candidate it pulses start, waits for done, and compares the returned 128-bit digest against a target. It stops on the first match, on range exhaustion, or on abort.

Parameters:
STEP, 1, BCD increment per candidate; legal range 1..9. Used to interleave N parallel cores as lo+k, lo+k+N, …
CNT_W, 27, width of tried_count; 27 bits covers 10^8 candidates.

Ports:
clk  in  1  clock
reset_n  in  1  reset; synchronous, active-low
go  in  1  one-cycle start request; accepted only in IDLE
abort  in  1  stop the search; honoured in any non-IDLE state
range_lo  in  32  first candidate, 8 BCD digits, MSD in [31:28]
range_hi  in  32  last candidate, inclusive, BCD
target_hash  in  128  digest to match, same byte order as md5_hash
md5_msg  out  64  candidate ASCII, first character in [63:56]
md5_start  out  1  one-cycle start pulse to the core
md5_done  in  1  one-cycle done pulse from the core
md5_hash  in  128  core digest, valid while md5_done=1
busy  out  1  high in every state except IDLE
found  out  1  sticky, set when a match is found
found_msg  out  64  ASCII of the matching candidate
exhausted  out  1  sticky, set when the range ends without a match
tried_count  out  CNT_W  number of digests compared in the current job

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-job drops any in-flight core result; the core is reset by the same reset_n.
- Latched at go: range_lo, range_hi, target_hash. go also clears found, exhausted, found_msg and tried_count.
- Candidate encoding: each byte of md5_msg = 8'h30 | BCD digit. md5_msg holds its value from ISSUE until the next ISSUE.
- FSM states: IDLE, ISSUE, WAIT, CHECK, NEXT, DRAIN.
  - IDLE, on go:
    - if range_lo > range_hi (unsigned compare of the BCD words; BCD preserves ordering): exhausted=1, stay IDLE, zero md5_start pulses.
    - otherwise: cand=range_lo, go to ISSUE.
  - ISSUE: md5_start=1 for exactly this cycle, then WAIT.
  - WAIT: on md5_done, register md5_hash, go to CHECK.
  - CHECK: tried_count+1. If the registered hash equals target: found=1, found_msg=md5_msg, go to IDLE. Otherwise go to NEXT.
  - NEXT: nxt = cand + STEP as a ripple BCD add with per-digit carry. If carry out of digit 7, or nxt > range_hi: exhausted=1, go to IDLE. Otherwise cand=nxt, go to ISSUE.
- The core accepts start only in its own idle state, so the ISSUE→start→done→CHECK→NEXT→ISSUE spacing keeps exactly one request outstanding. Per-candidate cost = core latency + 3 controller cycles.
- abort:
  - In ISSUE or WAIT the core is, or will be, busy, so go to DRAIN.
  - In CHECK or NEXT, go to IDLE.
  - In DRAIN, ignore md5_done except as the exit condition; never set found from a drained hash.
  - DRAIN → IDLE on md5_done.
  - abort sets neither found nor exhausted.
  - abort and md5_done in the same cycle in WAIT: go to IDLE, discard the hash.
- go in any non-IDLE state is ignored.
- Invalid BCD nibbles (>9) on range inputs are not detected; the caller guarantees valid BCD.
- No wrap: 99999999 + STEP terminates the job, never reaching 00000000.

Optional Feature:
MD5_CRACK_TIMEOUT_EN:
- Defined:
  - adds output timeout (1 bit, sticky, cleared by go) and an 8-bit watchdog counting cycles in WAIT/DRAIN, cleared on ISSUE.
  - at count 255 without md5_done: timeout=1, go to IDLE, found and exhausted unchanged.
- Undefined: no port, no counter; WAIT/DRAIN wait indefinitely.

Test Plan:
1. lo=12345670, hi=12345679, STEP=1, target=25d55ad283aa400af464c76d713c07ad (md5 of "12345678"), bench MD5 model as core -> 9 md5_start pulses, found=1, found_msg=64'h3132333435363738, tried_count=9, exhausted=0, busy=0.
2. lo=hi=00000000, target=0 -> one md5_start, md5_msg=64'h3030303030303030, exhausted=1, tried_count=1, found=0.
3. lo=99999998, hi=99999999, STEP=1, target non-matching -> 2 starts (…38, …39), exhausted=1, no start with 00000000.
4. lo=00000005, hi=00000004, go -> exhausted=1 next cycle, zero md5_start, busy never 1.
5. STEP=3, lo=00000007, hi=00000019, no match -> candidates 07,10,13,16,19 (digit carry checked), tried_count=5. Then abort asserted during WAIT of a new job -> no further start, busy high until md5_done, then IDLE; a subsequent go runs normally.
6. reset_n=0 for one cycle mid-WAIT -> all outputs 0 next cycle, state IDLE; with MD5_CRACK_TIMEOUT_EN and core done tied low -> timeout=1 after 255 WAIT cycles.
